// File: rtl/psum_ofifo_pkg.sv
// Shared sizing for the partial-sum output FIFO.
// Each lane entry packs both psum halves as {s1, s0}.
package psum_ofifo_pkg;

    localparam int PSUM_BW_DEF = 16;
    localparam int ENTRY_W_DEF = 2 * PSUM_BW_DEF;

    function automatic int entry_w(input int psum_bw);
        return 2 * psum_bw;
    endfunction

    // The occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/psum_ofifo_lane.sv
// Single-column FIFO lane: storage, read/write pointers and occupancy count.
// The pop request is only ever raised while the lane holds data.
module ofifo_lane
    import psum_ofifo_pkg::*;
#(
    parameter int DW    = ENTRY_W_DEF,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic          drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push;

    always_comb begin
        empty = (cnt_q == '0);
        full  = (cnt_q == CW'(DEPTH));
        // A full lane can still accept a write when the same edge frees a slot.
        push  = wr && (!full || pop);
        drop  = wr && full && !pop;

        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage is data only; stale contents are unreachable once pointers reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= din;
    end

    assign dout = mem_q[rptr_q];

endmodule

// File: rtl/psum_ofifo.sv
// Output collection FIFO below the last MAC row: per-column lanes absorb the
// diagonal skew and present a full aligned psum row once every lane has data.
module psum_ofifo
    import psum_ofifo_pkg::*;
#(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int depth   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in_s0,
    input  logic [psum_bw*col-1:0] in_s1,
    input  logic [col-1:0]         wr,
    input  logic                   cfg_2b,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out_s0,
    output logic [psum_bw*col-1:0] out_s1,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_ovf
);

    localparam int EW = entry_w(psum_bw);

    logic [EW-1:0]  lane_din  [col];
    logic [EW-1:0]  lane_dout [col];
    logic [col-1:0] lane_empty;
    logic [col-1:0] lane_full;
    logic [col-1:0] lane_drop;
    logic           pop;
    logic           ovf_q, ovf_d;

    for (genvar g = 0; g < col; g++) begin : g_lane
        // In 4-bit mode the upper half carries no information and is stored as zero.
        assign lane_din[g] = {(cfg_2b ? in_s1[psum_bw*g +: psum_bw] : {psum_bw{1'b0}}),
                              in_s0[psum_bw*g +: psum_bw]};

        ofifo_lane #(
            .DW    (EW),
            .DEPTH (depth)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[g]),
            .pop   (pop),
            .din   (lane_din[g]),
            .dout  (lane_dout[g]),
            .empty (lane_empty[g]),
            .full  (lane_full[g]),
            .drop  (lane_drop[g])
        );
    end

    always_comb begin
        o_valid = ~|lane_empty;
        o_full  = |lane_full;
        o_ready = ~o_full;
        pop     = rd && o_valid;
        ovf_d   = ovf_q || (|lane_drop);
        out_s0  = '0;
        out_s1  = '0;
        for (int i = 0; i < col; i++) begin
            if (o_valid) begin
                out_s0[psum_bw*i +: psum_bw] = lane_dout[i][psum_bw-1:0];
                out_s1[psum_bw*i +: psum_bw] = lane_dout[i][EW-1:psum_bw];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign o_ovf = ovf_q;

endmodule

// File: tb/tb_psum_ofifo.sv
// Directed bench for psum_ofifo: each task drives a scenario and checks
// outputs one time-step after the rising edge against hand-built vectors.
module tb_psum_ofifo;

    localparam int BW = 16;
    localparam int NC = 8;
    localparam int W  = BW * NC;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  in_s0, in_s1;
    logic [NC-1:0] wr;
    logic          cfg_2b;
    logic          rd;
    logic [W-1:0]  out_s0, out_s1;
    logic          o_valid, o_full, o_ready, o_ovf;

    int checks = 0;
    int errors = 0;

    psum_ofifo #(.psum_bw(BW), .col(NC), .depth(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_s0   (in_s0),
        .in_s1   (in_s1),
        .wr      (wr),
        .cfg_2b  (cfg_2b),
        .rd      (rd),
        .out_s0  (out_s0),
        .out_s1  (out_s1),
        .o_valid (o_valid),
        .o_full  (o_full),
        .o_ready (o_ready),
        .o_ovf   (o_ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; wr = '0; rd = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        in_s0 = '0; in_s1 = '0; cfg_2b = 1'b1;
        do_reset();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
        checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", o_full); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", o_ready); end
        checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", o_ovf); end
        checks++; if (out_s0 !== '0 || out_s1 !== '0) begin errors++; $display("FAIL reset_out got %h/%h want 0", out_s0, out_s1); end
    endtask

    task automatic test_basic();
        logic [W-1:0] e0, e1;
        for (int i = 0; i < NC; i++) begin
            e0[BW*i +: BW] = BW'(i + 1);
            e1[BW*i +: BW] = BW'(16'h100 + i);
        end
        in_s0 = e0; in_s1 = e1; cfg_2b = 1'b1; wr = 8'hFF;
        step();
        wr = '0;
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", o_valid); end
        checks++; if (out_s0 !== e0) begin errors++; $display("FAIL basic_s0 got %h want %h", out_s0, e0); end
        checks++; if (out_s1 !== e1) begin errors++; $display("FAIL basic_s1 got %h want %h", out_s1, e1); end
        rd = 1'b1;
        step();
        rd = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_pop_valid got %b want 0", o_valid); end
        checks++; if (out_s0 !== '0 || out_s1 !== '0) begin errors++; $display("FAIL basic_pop_out got %h/%h want 0", out_s0, out_s1); end
    endtask

    task automatic test_skew();
        logic [W-1:0] e0;
        for (int i = 0; i < NC; i++) e0[BW*i +: BW] = BW'(16'h20 + i);
        in_s0 = e0; in_s1 = '0; cfg_2b = 1'b1;
        for (int i = 0; i < NC; i++) begin
            wr = NC'(1) << i;
            step();
            checks++;
            if (o_valid !== (i == NC - 1)) begin
                errors++; $display("FAIL skew_valid_%0d got %b want %b", i, o_valid, (i == NC - 1));
            end
        end
        wr = '0;
        checks++; if (out_s0 !== e0) begin errors++; $display("FAIL skew_data got %h want %h", out_s0, e0); end
        rd = 1'b1; step(); rd = 1'b0;
    endtask

    task automatic test_mode4();
        logic [W-1:0] e0;
        for (int i = 0; i < NC; i++) e0[BW*i +: BW] = BW'(16'h3000 + i);
        in_s0 = e0; in_s1 = {W{1'b1}}; cfg_2b = 1'b0; wr = 8'hFF;
        step();
        wr = '0; cfg_2b = 1'b1;
        checks++; if (out_s1 !== '0) begin errors++; $display("FAIL mode4_s1 got %h want 0", out_s1); end
        checks++; if (out_s0 !== e0) begin errors++; $display("FAIL mode4_s0 got %h want %h", out_s0, e0); end
        rd = 1'b1; step(); rd = 1'b0;
    endtask

    task automatic fill16();
        cfg_2b = 1'b1; in_s1 = '0;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < NC; i++) in_s0[BW*i +: BW] = BW'((k << 8) | i);
            wr = 8'hFF;
            step();
        end
        wr = '0;
    endtask

    task automatic test_full_ovf();
        do_reset();
        fill16();
        checks++; if (o_full !== 1'b1 || o_ready !== 1'b0) begin errors++; $display("FAIL full_flags got %b%b want 10", o_full, o_ready); end
        checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL full_ovf_early got %b want 0", o_ovf); end
        in_s0[BW-1:0] = 16'hAA00; wr = 8'h01;
        step();
        wr = '0;
        checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", o_ovf); end
        checks++; if (out_s0[BW-1:0] !== 16'h0000 || o_valid !== 1'b1) begin errors++; $display("FAIL ovf_head got %h/%b want 0000/1", out_s0[BW-1:0], o_valid); end
        rd = 1'b1; step(); rd = 1'b0;
        checks++; if (out_s0[BW-1:0] !== 16'h0100) begin errors++; $display("FAIL ovf_next got %h want 0100", out_s0[BW-1:0]); end
        checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", o_ovf); end

        // Write to full lane 0 alongside a pop: accepted, no overflow.
        do_reset();
        fill16();
        in_s0[BW-1:0] = 16'hAA00; wr = 8'h01; rd = 1'b1;
        step();
        wr = '0; rd = 1'b0;
        checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL poppush_ovf got %b want 0", o_ovf); end
        checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL poppush_full got %b want 1", o_full); end
        checks++; if (out_s0[BW-1:0] !== 16'h0100) begin errors++; $display("FAIL poppush_head got %h want 0100", out_s0[BW-1:0]); end
        for (int i = 1; i < NC; i++) in_s0[BW*i +: BW] = BW'(16'hAA00 | i);
        wr = 8'hFE;
        step();
        wr = '0;
        for (int k = 1; k < 16; k++) begin
            checks++;
            if (out_s0[BW-1:0] !== BW'(k << 8) || o_valid !== 1'b1) begin
                errors++; $display("FAIL drain_%0d got %h/%b want %h/1", k, out_s0[BW-1:0], o_valid, BW'(k << 8));
            end
            rd = 1'b1; step(); rd = 1'b0;
        end
        checks++; if (out_s0[BW-1:0] !== 16'hAA00 || out_s0[BW +: BW] !== 16'hAA01) begin errors++; $display("FAIL drain_last got %h want aa01aa00", out_s0[2*BW-1:0]); end
        rd = 1'b1; step(); rd = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", o_valid); end
    endtask

    task automatic test_empty_rd_wrap();
        logic [W-1:0] e0;
        do_reset();
        rd = 1'b1; step(); rd = 1'b0;
        checks++; if (o_valid !== 1'b0 || out_s0 !== '0) begin errors++; $display("FAIL emptyrd got %b/%h want 0/0", o_valid, out_s0); end
        for (int i = 0; i < NC; i++) e0[BW*i +: BW] = BW'(16'h5A00 + i);
        in_s0 = e0; wr = 8'hFF; step(); wr = '0;
        checks++; if (out_s0 !== e0) begin errors++; $display("FAIL emptyrd_head got %h want %h", out_s0, e0); end
        rd = 1'b1; step(); rd = 1'b0;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NC; i++) e0[BW*i +: BW] = BW'((n << 4) + i);
            in_s0 = e0; wr = 8'hFF; step(); wr = '0;
            checks++;
            if (out_s0 !== e0) begin errors++; $display("FAIL wrap_%0d got %h want %h", n, out_s0, e0); end
            rd = 1'b1; step(); rd = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_s0 = {W{1'b1}}; in_s1 = {W{1'b1}}; cfg_2b = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wr = 8'hFF; step();
        end
        wr = '0;
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got %b want 1", o_valid); end
        do_reset();
        checks++; if (o_valid !== 1'b0 || o_full !== 1'b0 || o_ovf !== 1'b0) begin errors++; $display("FAIL mid_flags got %b%b%b want 000", o_valid, o_full, o_ovf); end
        checks++; if (out_s0 !== '0 || out_s1 !== '0) begin errors++; $display("FAIL mid_out got %h/%h want 0", out_s0, out_s1); end
    endtask

    initial begin
        reset = 1'b1; wr = '0; rd = 1'b0; cfg_2b = 1'b1; in_s0 = '0; in_s1 = '0;
        test_reset();
        test_basic();
        test_skew();
        test_mode4();
        test_full_ovf();
        test_empty_rd_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/psum_ofifo.md
# psum_ofifo

Output collection FIFO directly downstream of the last MAC row in the array. Each column lane captures that column's bottom-of-array partial sums (both psum halves) whenever the column's valid bit fires, absorbing the diagonal skew between columns. A full row of psums is presented as one aligned word once every lane holds data, and is consumed by the SFU/accumulation stage via a read strobe.

## Interface
- psum_bw, 16, width of one partial sum
- col, 8, number of column lanes (matches array column count)
- depth, 16, entries per lane; power of two, ≥2

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_s0  in  psum_bw*col  psum half 0 from last row; lane i = bits [psum_bw*i +: psum_bw]
- in_s1  in  psum_bw*col  psum half 1 from last row, same lane packing
- wr  in  col  per-lane write strobe (last row's valid bits)
- cfg_2b  in  1  1 = 2-bit mode (both halves meaningful); 0 = 4-bit mode (half 1 stored as zero)
- rd  in  1  pop one aligned row from all lanes
- out_s0  out  psum_bw*col  head entry half 0 of every lane
- out_s1  out  psum_bw*col  head entry half 1 of every lane
- o_valid  out  1  every lane non-empty
- o_full  out  1  any lane full
- o_ready  out  1  no lane full (= ~o_full)
- o_ovf  out  1  sticky: a write was dropped on a full lane

## Operation
- Lane i stores {s1, s0}; s1 written as 0 when cfg_2b=0 at the write edge.
- Write: wr[i]=1 and lane i not full → entry stored at wptr, wptr+1, count+1.
- Write to full lane with no pop in the same cycle → data dropped, o_ovf set to 1; held until reset.
- Full lane with wr[i]=1 and accepted pop same cycle → write accepted, count unchanged.
- Read: rd=1 and o_valid=1 → every lane pops (rptr+1, count−1). rd while o_valid=0 ignored, no state change.
- Simultaneous write+pop on a lane: count unchanged, both pointers advance.
- Pointers wrap modulo depth; count ranges 0..depth, width $clog2(depth)+1.
- out_s0/out_s1 are first-word-fall-through: combinationally the head entry of each lane when o_valid=1; forced to all-zero when o_valid=0.
- Lanes write independently (skewed arrival); reads always pop all lanes together.

## Timing
- Reset (synchronous, checked at rising edge): all pointers and counts 0, o_valid=0, o_full=0, o_ready=1, o_ovf=0, out_s0=out_s1=0. Reset mid-operation discards all stored data.
- o_valid/o_full/o_ready are combinational from registered counts; they reflect writes/pops one cycle after the edge that performs them.
- Write-to-read latency: data written at edge N is visible on out_s* (if all lanes non-empty) after edge N, i.e. during cycle N+1.
- Back-to-back rd every cycle is supported while o_valid stays 1.
- No combinational path from wr or in_s* to any output; rd affects outputs only after the clock edge.

## Structure
- Shared package: lane entry width constant (2*psum_bw), count-width function/constant derived from depth.
- One sub-module: ofifo_lane (single-lane FIFO: storage, wptr/rptr, count, empty/full, drop/overflow pulse); psum_ofifo instantiates col copies via generate, ANDs lane non-empty into o_valid, ORs lane full into o_full and lane drop pulses into o_ovf.

## Test plan
- Reset then wr=8'hFF once with lane i s0=i+1, s1=0x100+i, cfg_2b=1 → next cycle o_valid=1, out_s0 lane i = i+1, out_s1 lane i = 0x100+i; rd=1 → o_valid=0, outputs 0.
- Skewed writes: wr[i] asserted in cycle i (one lane per cycle) → o_valid stays 0 until the cycle after lane 7 writes, then 1 with all lanes aligned.
- cfg_2b=0 write with in_s1 all 0xFFFF → out_s1 reads 0 on every lane.
- Fill lane 0 with 16 writes, other lanes with 16 → o_full=1, o_ready=0; 17th write on lane 0 without rd → o_ovf=1, head data unchanged; same 17th write with rd=1 → accepted, o_ovf stays 0, count stays 16.
- rd=1 while empty → no state change, o_valid=0, no pointer movement; then wrap test: 40 write/read pairs → data order preserved across pointer wrap.
- Reset asserted with 5 entries stored → next cycle o_valid=0, o_full=0, o_ovf=0, outputs 0.
